// File: rtl/alu_exec_stage.sv
// Two-stage pipelined ALU execute stage with valid/ready handshake on both sides.
// S1 registers the incoming op; S2 computes and registers result, flags and tag.

package alu_pkg;
  typedef enum logic [3:0] {
    ADD            = 4'd0,
    SUBTRACT       = 4'd1,
    XOR            = 4'd2,
    OR             = 4'd3,
    AND            = 4'd4,
    SHIFT_LT_LOG   = 4'd5,
    SHIFT_RT_LOG   = 4'd6,
    SHIFT_RT_AR    = 4'd7,
    BARREL_SHIFTER = 4'd8,
    IS_EQUAL       = 4'd9,
    IS_GREATER     = 4'd10
  } ALU_OP_CODE;
endpackage

module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_carry,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned SH_W = $clog2(WIDTH);

  logic             s1_valid;
  logic [3:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [TAG_W-1:0] s1_tag;

  logic             adv2;
  logic [SH_W-1:0]  sh;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] rot;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             err;

  assign adv2     = !out_valid || out_ready;
  assign in_ready = !s1_valid || adv2;

  // When in_ready is high, S1 is either empty or draining into S2 this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        s1_op  <= in_op;
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_tag <= in_tag;
      end
    end
  end

  always_comb begin
    sh    = s1_b[SH_W-1:0];
    sum   = {1'b0, s1_a} + {1'b0, s1_b};
    rot   = {s1_a, s1_a} << sh;
    res   = '0;
    carry = 1'b0;
    err   = 1'b0;
    case (s1_op)
      ADD: begin
        res   = sum[WIDTH-1:0];
        carry = sum[WIDTH];
      end
      SUBTRACT: begin
        res   = s1_a - s1_b;
        carry = s1_a < s1_b;
      end
      XOR:            res = s1_a ^ s1_b;
      OR:             res = s1_a | s1_b;
      AND:            res = s1_a & s1_b;
      SHIFT_LT_LOG:   res = s1_a << sh;
      SHIFT_RT_LOG:   res = s1_a >> sh;
      SHIFT_RT_AR:    res = $unsigned($signed(s1_a) >>> sh);
      BARREL_SHIFTER: res = rot[2*WIDTH-1:WIDTH];
      IS_EQUAL:       res[0] = (s1_a == s1_b);
      IS_GREATER:     res[0] = (s1_a > s1_b);
      default:        err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_zero   <= 1'b0;
      out_carry  <= 1'b0;
      out_err    <= 1'b0;
      out_tag    <= '0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= res;
        out_zero   <= (res == '0);
        out_carry  <= carry;
        out_err    <= err;
        out_tag    <= s1_tag;
      end
    end
  end

endmodule
